// File: rtl/pixel_merger_pkg.sv
// rtl/pixel_merger_pkg.sv - shared pixel types, background constant and merger FSM states
package pixel_merger_pkg;

    typedef struct packed {
        logic [7:0]  red;
        logic [7:0]  green;
        logic [7:0]  blue;
        logic [15:0] depth;
    } pixel_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        pixel_t     pixel;
    } pixel_info_t;

    // Cleared framebuffer: black, farthest possible depth
    localparam pixel_t BACKGROUND_PIXEL = '{red: 8'd0, green: 8'd0, blue: 8'd0, depth: 16'hFFFF};

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE,
        CLEAR
    } merger_state_t;

endpackage

// File: rtl/pixel_merger_rr_arbiter.sv
// rtl/pixel_merger_rr_arbiter.sv - round-robin arbiter, pointer moves past the winner on accept
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     request,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);
    logic [IDX_W-1:0] ptr;
    int               lane;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        lane        = 0;
        for (int k = 0; k < N; k++) begin
            lane = (int'(ptr) + k) % N;
            if (!grant_valid && request[lane]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(lane);
                grant[lane] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept && grant_valid) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/pixel_merger.sv
// rtl/pixel_merger.sv - lane merger with z-buffer write and framebuffer clear sweep
// PIXEL_MERGER_DEPTH_TEST_EN enables the read/compare depth test; otherwise pixels are painted in order.
module pixel_merger
    import pixel_merger_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19
) (
    input  logic                      clock,
    input  logic                      reset,
    input  pixel_info_t [N_LANES-1:0] data_in,
    input  logic [N_LANES-1:0]        data_write,
    output logic [N_LANES-1:0]        output_written,
    input  logic                      clear,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  pixel_t                    mem_rd_data,
    output logic                      mem_wr_en,
    output pixel_t                    mem_wr_data,
    output logic                      busy,
    output logic                      overrun
);
    localparam int                IDX_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    merger_state_t      state;
    pixel_info_t        held [N_LANES];
    logic [N_LANES-1:0] pending;
    logic [IDX_W-1:0]   g_idx;
    logic [ADDR_W-1:0]  addr_q;
    logic               clear_req;

    logic [N_LANES-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [N_LANES-1:0] g_onehot;
    logic [N_LANES-1:0] releasing;
    logic               clear_go;
    logic               take;
    logic               in_range;
    logic [ADDR_W-1:0]  pix_addr;
    pixel_info_t        cand;

    rr_arbiter #(.N(N_LANES), .IDX_W(IDX_W)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .request     (pending),
        .accept      (take),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign cand      = held[grant_idx];
    assign in_range  = (int'(cand.x) < WIDTH) && (int'(cand.y) < HEIGHT);
    assign pix_addr  = ADDR_W'(cand.y) * ADDR_W'(WIDTH) + ADDR_W'(cand.x);
    assign clear_go  = (state == IDLE) && (clear || clear_req);
    assign take      = (state == IDLE) && !clear_go && grant_valid;
    assign g_onehot  = N_LANES'(1) << g_idx;
    assign releasing = (state == WRITE) ? g_onehot : '0;
    assign busy      = (state != IDLE) || (|pending);
    // The read address is presented in the grant cycle so data lands in COMPARE
    assign mem_addr  = take ? pix_addr : addr_q;

`ifdef PIXEL_MERGER_DEPTH_TEST_EN
    assign mem_rd_en = take && in_range;
`else
    logic unused_rd_data;
    assign mem_rd_en      = 1'b0;
    assign unused_rd_data = ^mem_rd_data;
`endif

    // A lane re-armed by its acknowledge may refill in that same cycle
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (data_write[i] && (!pending[i] || releasing[i])) begin
                held[i] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            pending        <= '0;
            g_idx          <= '0;
            addr_q         <= '0;
            clear_req      <= 1'b0;
            output_written <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_data    <= '0;
            overrun        <= 1'b0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (data_write[i]) begin
                    if (!pending[i] || releasing[i]) begin
                        pending[i] <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else if (releasing[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            if (clear && (state == COMPARE || state == WRITE)) begin
                clear_req <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clear_go) begin
                        state       <= CLEAR;
                        clear_req   <= 1'b0;
                        addr_q      <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= BACKGROUND_PIXEL;
                    end else if (grant_valid) begin
                        g_idx  <= grant_idx;
                        addr_q <= pix_addr;
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
                        if (in_range) begin
                            state <= COMPARE;
                        end else begin
                            state          <= WRITE;
                            output_written <= grant;
                        end
`else
                        state          <= WRITE;
                        output_written <= grant;
                        mem_wr_en      <= in_range;
                        mem_wr_data    <= cand.pixel;
`endif
                    end
                end
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
                COMPARE: begin
                    state          <= WRITE;
                    output_written <= g_onehot;
                    mem_wr_en      <= held[g_idx].pixel.depth < mem_rd_data.depth;
                    mem_wr_data    <= held[g_idx].pixel;
                end
`endif
                WRITE: begin
                    state          <= IDLE;
                    output_written <= '0;
                    mem_wr_en      <= 1'b0;
                end
                CLEAR: begin
                    if (addr_q == LAST_ADDR) begin
                        state     <= IDLE;
                        mem_wr_en <= 1'b0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_merger.sv
// tb/tb_pixel_merger.sv - directed self-checking bench for pixel_merger on a 40x12 framebuffer
module tb_pixel_merger;
    import pixel_merger_pkg::*;

    localparam int N    = 4;
    localparam int W    = 40;
    localparam int H    = 12;
    localparam int AW   = 9;
    localparam int AREA = W * H;
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
    localparam int DT = 1;
`else
    localparam int DT = 0;
`endif
    localparam int L = DT ? 3 : 2;
    localparam int P = DT ? 3 : 2;

    logic                clock;
    logic                reset;
    pixel_info_t [N-1:0] data_in;
    logic [N-1:0]        data_write;
    logic [N-1:0]        output_written;
    logic                clear;
    logic [AW-1:0]       mem_addr;
    logic                mem_rd_en;
    pixel_t              mem_rd_data;
    logic                mem_wr_en;
    pixel_t              mem_wr_data;
    logic                busy;
    logic                overrun;

    pixel_merger #(.N_LANES(N), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_write     (data_write),
        .output_written (output_written),
        .clear          (clear),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .busy           (busy),
        .overrun        (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    pixel_t ram [2**AW];
    always @(posedge clock) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int            ack_cyc[$];
    int            ack_lane[$];
    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    pixel_t        wr_data[$];
    int            rd_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (output_written[i]) begin
                    ack_cyc.push_back(cyc);
                    ack_lane.push_back(i);
                end
            end
            if (mem_wr_en) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wr_data);
            end
            if (mem_rd_en) rd_cnt++;
        end
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, longint'(busy), 0);
    endtask

    task automatic one_px(input int lane, input pixel_info_t p, output int t);
        data_in[lane] = p;
        data_write    = N'(1) << lane;
        t             = cyc;
        tick(1);
        data_write    = '0;
    endtask

    function automatic pixel_info_t mk(input int x, input int y, input int d);
        pixel_info_t p;
        p.x           = 10'(x);
        p.y           = 10'(y);
        p.pixel.red   = 8'(x + 1);
        p.pixel.green = 8'(y + 2);
        p.pixel.blue  = 8'(d + 3);
        p.pixel.depth = 16'(d);
        return p;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, a0, w0, r0;
        pixel_info_t p, q;

        reset = 1'b1; clear = 1'b0; data_write = '0; data_in = '0;
        tick(3);
        reset = 1'b0;
        chk("rst_ack", output_written, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // Full clear; a second clear mid-sweep must be ignored
        w0 = wr_cyc.size();
        clear = 1'b1; t0 = cyc; tick(1); clear = 1'b0;
        chk("clr_busy", busy, 1);
        tick(10);
        clear = 1'b1; tick(1); clear = 1'b0;
        wait_idle("clr");
        tick(5);
        chk("clr_count", wr_cyc.size() - w0, 480);
        chk("clr_first_cyc", wr_cyc[w0] - t0, 1);
        chk("clr_last_cyc", wr_cyc[w0 + 479] - t0, 480);
        chk("clr_last_addr", wr_addr[w0 + 479], 479);
        chk("clr_data", wr_data[w0 + 479], 40'h00_0000_FFFF);

        // Single pixel lane 0 at (3,2) -> address 83
        a0 = ack_cyc.size(); w0 = wr_cyc.size(); r0 = rd_cnt;
        p = mk(3, 2, 10);
        one_px(0, p, t0);
        wait_idle("px");
        chk("px_ack_n", ack_cyc.size() - a0, 1);
        chk("px_ack_lane", ack_lane[a0], 0);
        chk("px_ack_cyc", ack_cyc[a0] - t0, L);
        chk("px_wr_addr", wr_addr[w0], 83);
        chk("px_wr_cyc", wr_cyc[w0] - t0, L);
        chk("px_wr_data", wr_data[w0], p.pixel);
        chk("px_rd", rd_cnt - r0, DT);

        // Depth: 5 beats 10, 9 loses to 5, 5 ties 5
        a0 = ack_cyc.size(); w0 = wr_cyc.size();
        one_px(0, mk(3, 2, 5), t0); wait_idle("d5");
        chk("d5_wr", wr_cyc.size() - w0, 1);
        w0 = wr_cyc.size();
        one_px(2, mk(3, 2, 9), t0); wait_idle("d9");
        chk("d9_wr", wr_cyc.size() - w0, 1 - DT);
        chk("d9_ack_lane", ack_lane[a0 + 1], 2);
        chk("d9_ack_cyc", ack_cyc[a0 + 1] - t0, L);
        w0 = wr_cyc.size();
        one_px(3, mk(3, 2, 5), t0); wait_idle("tie");
        chk("tie_wr", wr_cyc.size() - w0, 1 - DT);
        chk("tie_ack_lane", ack_lane[a0 + 2], 3);
        chk("depth_ack_n", ack_cyc.size() - a0, 3);

        // All four lanes at once, pointer back at lane 0
        a0 = ack_cyc.size(); w0 = wr_cyc.size();
        for (int k = 0; k < N; k++) data_in[k] = mk(10 + k, 3, 1);
        data_write = 4'hF; t0 = cyc; tick(1); data_write = '0;
        wait_idle("rr");
        chk("rr_ack_n", ack_cyc.size() - a0, 4);
        for (int k = 0; k < N; k++) begin
            chk("rr_ack_lane", ack_lane[a0 + k], k);
            chk("rr_ack_cyc", ack_cyc[a0 + k] - t0, L + P * k);
            chk("rr_wr_addr", wr_addr[w0 + k], 130 + k);
        end

        // Out of range x=40, then the last in-range corner (39,11)
        a0 = ack_cyc.size(); w0 = wr_cyc.size(); r0 = rd_cnt;
        one_px(2, mk(40, 0, 7), t0); wait_idle("oor");
        chk("oor_ack_cyc", ack_cyc[a0] - t0, 2);
        chk("oor_wr", wr_cyc.size() - w0, 0);
        chk("oor_rd", rd_cnt - r0, 0);
        one_px(1, mk(39, 11, 7), t0); wait_idle("edge");
        chk("edge_wr_addr", wr_addr[w0], 479);
        chk("edge_ack_cyc", ack_cyc[a0 + 1] - t0, L);

        // Clear during a pixel; lane 2 arrives mid-sweep
        a0 = ack_cyc.size(); w0 = wr_cyc.size();
        p = mk(5, 5, 0);
        q = mk(20, 6, 100);
        one_px(0, p, t0);
        tick(1);
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(17);
        one_px(2, q, t2);
        wait_idle("mclr");
        chk("mclr_wr_n", wr_cyc.size() - w0, 482);
        chk("mclr_px_addr", wr_addr[w0], 205);
        chk("mclr_px_cyc", wr_cyc[w0] - t0, L);
        chk("mclr_first", wr_cyc[w0 + 1] - t0, L + 2);
        chk("mclr_last", wr_cyc[w0 + 480] - t0, L + 481);
        chk("mclr_ack0_cyc", ack_cyc[a0] - t0, L);
        chk("mclr_ack2_lane", ack_lane[a0 + 1], 2);
        chk("mclr_ack2_cyc", ack_cyc[a0 + 1] - t0, L + 482 + L - 1);
        chk("mclr_px2_addr", wr_addr[w0 + 481], 260);

        // Refill in the acknowledge cycle is captured, not an overrun
        a0 = ack_cyc.size(); w0 = wr_cyc.size();
        one_px(3, mk(1, 1, 50), t0);
        tick(L - 1);
        one_px(3, mk(2, 1, 60), t1);
        wait_idle("refill");
        chk("refill_ack_n", ack_cyc.size() - a0, 2);
        chk("refill_ack2_cyc", ack_cyc[a0 + 1] - t1, L);
        chk("refill_wr_addr", wr_addr[w0 + 1], 42);
        chk("refill_overrun", overrun, 0);

        // Overrun: second pulse on a pending lane is dropped
        a0 = ack_cyc.size(); w0 = wr_cyc.size();
        p = mk(7, 7, 2);
        one_px(1, p, t0);
        one_px(1, mk(8, 7, 3), t1);
        chk("ovr_flag", overrun, 1);
        wait_idle("ovr");
        chk("ovr_ack_n", ack_cyc.size() - a0, 1);
        chk("ovr_wr_n", wr_cyc.size() - w0, 1);
        chk("ovr_wr_addr", wr_addr[w0], 287);
        chk("ovr_wr_data", wr_data[w0], p.pixel);

        // Reset in the middle of a sweep
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(5);
        reset = 1'b1; tick(1);
        chk("mrst_wr_en", mem_wr_en, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_busy", busy, 0);
        reset = 1'b0;
        w0 = wr_cyc.size();
        tick(20);
        chk("mrst_no_wr", wr_cyc.size() - w0, 0);
        chk("mrst_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
